// File: rtl/bus_client_gen2_if.sv
// Request/acknowledge bus between a traffic-generating client and the arbiter.
// Carries address, direction and data for one transfer at a time.
// The client drives the request side; the arbiter/server drives ack and read data.
interface bus_client_gen2_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  rq;
  logic                  ack;
  logic                  wr_ni;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] dataW;
  logic [DATA_WIDTH-1:0] dataR;

  modport master (
    output rq, wr_ni, address, dataW,
    input  ack, dataR
  );

  modport slave (
    input  rq, wr_ni, address, dataW,
    output ack, dataR
  );
endinterface

// File: rtl/bus_client_gen2.sv
// Traffic generator client: LFSR-paced random or write/readback traffic over an address window.
// Latency: rq rises one cycle after an IDLE edge with en=1 and lfsr[0]=1; minimum transfer 1 REQ + 1 GAP cycle.
// Backpressure: rq is held with stable address/direction/data until ack or timeout; a timed-out transfer is retried.
module bus_client_gen2 #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 4,
  parameter int                    ADDR_BASE   = 0,
  parameter int                    ADDR_LIMIT  = 3,
  parameter int                    ADDR_STRIDE = 1,
  parameter int                    MODE        = 0,
  parameter int                    LFSR_WIDTH  = 5,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED   = LFSR_WIDTH'(5'b00101),
  parameter int                    TIMEOUT     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  bus_client_gen2_if.master     bus,
  output logic [DATA_WIDTH-1:0] dataR_q,
  output logic [15:0]           wr_count,
  output logic [15:0]           rd_count,
  output logic [15:0]           err_count,
  output logic [7:0]            timeout_count,
  output logic                  err_flag
);

  // Maximal-length tap masks (bit i set = stage i+1 feeds the XOR).
  function automatic logic [15:0] tap_mask(input int w);
    case (w)
      3:       tap_mask = 16'h0006;
      4:       tap_mask = 16'h000C;
      5:       tap_mask = 16'h0014;
      6:       tap_mask = 16'h0030;
      7:       tap_mask = 16'h0060;
      8:       tap_mask = 16'h00B8;
      9:       tap_mask = 16'h0110;
      10:      tap_mask = 16'h0240;
      11:      tap_mask = 16'h0500;
      12:      tap_mask = 16'h0829;
      13:      tap_mask = 16'h100D;
      14:      tap_mask = 16'h2015;
      15:      tap_mask = 16'h6000;
      16:      tap_mask = 16'hD008;
      default: tap_mask = 16'h0000;
    endcase
  endfunction

  localparam logic [15:0] TAPS = tap_mask(LFSR_WIDTH);
  localparam int          TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t                  state, state_nxt;
  logic                    start, done, tmo;
  logic [TW-1:0]           tcnt;
  logic [LFSR_WIDTH-1:0]   lfsr;
  logic                    lfsr_fb;
  logic                    rq_q, wr_ni_q;
  logic [ADDR_WIDTH-1:0]   address_q, addr_next;
  logic [ADDR_WIDTH:0]     addr_sum;
  logic [DATA_WIDTH-1:0]   dataW_q, shadow;
  logic                    phase_rd;

  assign bus.rq      = rq_q;
  assign bus.wr_ni   = wr_ni_q;
  assign bus.address = address_q;
  assign bus.dataW   = dataW_q;

  assign lfsr_fb  = ^(lfsr & TAPS[LFSR_WIDTH-1:0]);

  // The extra sum bit keeps a carry past 2^ADDR_WIDTH from wrapping back into the window.
  assign addr_sum  = {1'b0, address_q} + (ADDR_WIDTH+1)'(ADDR_STRIDE);
  assign addr_next = (addr_sum > (ADDR_WIDTH+1)'(ADDR_LIMIT)) ? ADDR_WIDTH'(ADDR_BASE)
                                                              : addr_sum[ADDR_WIDTH-1:0];

  // Next-state decode; ack takes priority over a timeout on the same edge.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done      = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        if (en && lfsr[0]) begin
          state_nxt = REQ;
          start     = 1'b1;
        end
      end
      REQ: begin
        if (bus.ack) begin
          state_nxt = GAP;
          done      = 1'b1;
        end else if (TIMEOUT != 0 && tcnt == TLAST) begin
          state_nxt = GAP;
          tmo       = 1'b1;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, registered rq and the REQ-cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rq_q  <= 1'b0;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      rq_q  <= (state_nxt == REQ);
      if (start)
        tcnt <= '0;
      else if (state == REQ)
        tcnt <= tcnt + 1'b1;
    end
  end

  // Pacing LFSR advances only while idle so pacing is independent of transfer length.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      lfsr <= LFSR_SEED;
    else if (state == IDLE)
      lfsr <= {lfsr[LFSR_WIDTH-2:0], lfsr_fb};
  end

  // Request fields, completion bookkeeping and statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ni_q       <= 1'b1;
      address_q     <= ADDR_WIDTH'(ADDR_BASE);
      dataW_q       <= '0;
      dataR_q       <= '0;
      shadow        <= '0;
      phase_rd      <= 1'b0;
      wr_count      <= '0;
      rd_count      <= '0;
      err_count     <= '0;
      timeout_count <= '0;
      err_flag      <= 1'b0;
    end else begin
      // address and dataW double as the window pointer and data counter, so they
      // only move on completion and stay stable through REQ and any retry.
      if (start)
        wr_ni_q <= (MODE == 0) ? lfsr[1] : phase_rd;
      if (done) begin
        phase_rd <= ~phase_rd;
        if (wr_ni_q) begin
          rd_count <= rd_count + 16'd1;
          dataR_q  <= bus.dataR;
          if (MODE == 1 && bus.dataR != shadow) begin
            if (err_count != 16'hFFFF)
              err_count <= err_count + 16'd1;
            err_flag <= 1'b1;
          end
        end else begin
          wr_count <= wr_count + 16'd1;
          shadow   <= dataW_q;
          dataW_q  <= dataW_q + 1'b1;
        end
        // In readback mode the address holds across the write so the read hits it.
        if (MODE == 0 || wr_ni_q)
          address_q <= addr_next;
      end
      if (tmo && timeout_count != 8'hFF)
        timeout_count <= timeout_count + 8'd1;
    end
  end

endmodule
